// File: rtl/muldiv_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// muldiv_pkg : shared constants, op codes and FSM states for the mul/div unit
// Revision   : 1.0
// ----------------------------------------------------------------------------
package muldiv_pkg;

  localparam int WIDTH = 32;
  localparam int CNT_W = 5;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/muldiv_step.sv
`default_nettype none
// ----------------------------------------------------------------------------
// muldiv_step : one shift-add multiply or restoring-divide iteration
// Revision    : 1.0
// ----------------------------------------------------------------------------
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             is_div_i,
  input  logic [WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0] shreg_i,
  input  logic [WIDTH-1:0] opnd_i,
  output logic [WIDTH-1:0] acc_o,
  output logic [WIDTH-1:0] shreg_o
);

  logic [WIDTH:0]   x;
  logic [WIDTH:0]   y;
  logic [WIDTH+1:0] sum;
  logic [WIDTH:0]   msum;

  // Single 33-bit adder: subtract mode for division, add mode for multiply.
  always_comb begin
    x = is_div_i ? {acc_i, shreg_i[WIDTH-1]} : {1'b0, acc_i};
    y = {1'b0, opnd_i};
    sum = {1'b0, x} + {1'b0, (is_div_i ? ~y : y)} + {{(WIDTH+1){1'b0}}, is_div_i};
    msum = {1'b0, acc_i};
    acc_o = acc_i;
    shreg_o = shreg_i;
    if (is_div_i) begin
      // Carry out means the trial subtraction did not borrow.
      if (sum[WIDTH+1]) begin
        acc_o   = sum[WIDTH-1:0];
        shreg_o = {shreg_i[WIDTH-2:0], 1'b1};
      end else begin
        acc_o   = x[WIDTH-1:0];
        shreg_o = {shreg_i[WIDTH-2:0], 1'b0};
      end
    end else begin
      if (shreg_i[0]) begin
        msum = sum[WIDTH:0];
      end
      acc_o   = msum[WIDTH:1];
      shreg_o = {msum[0], shreg_i[WIDTH-1:1]};
    end
  end

endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// muldiv_unit : iterative mult/div engine owning the HI/LO pair
// Revision    : 1.0
// ----------------------------------------------------------------------------
module muldiv_unit #(
  parameter int WIDTH = muldiv_pkg::WIDTH,
  parameter int CNT_W = muldiv_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cancel_i,
  input  logic             mthi_i,
  input  logic             mtlo_i,
  input  logic [WIDTH-1:0] wd_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             busy_o,
  output logic             done_o
);

  import muldiv_pkg::*;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic             is_div_q, is_div_d;
  logic             neg_q, neg_d;
  logic             rem_neg_q, rem_neg_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0]   step_acc;
  logic [WIDTH-1:0]   step_shreg;
  logic               is_signed;
  logic               start_div;
  logic [WIDTH-1:0]   a_abs;
  logic [WIDTH-1:0]   b_abs;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div_i (is_div_q),
    .acc_i    (acc_q),
    .shreg_i  (shreg_q),
    .opnd_i   (opnd_q),
    .acc_o    (step_acc),
    .shreg_o  (step_shreg)
  );

  always_comb begin
    is_signed = ~op_i[0];
    start_div = op_i[1];
    a_abs = (is_signed && a_i[WIDTH-1]) ? (~a_i + WIDTH'(1)) : a_i;
    b_abs = (is_signed && b_i[WIDTH-1]) ? (~b_i + WIDTH'(1)) : b_i;

    // Post-correction of the unsigned core result; divide-by-zero forces
    // an all-ones quotient while the remainder path naturally yields a.
    prod     = {acc_q, shreg_q};
    prod_fix = neg_q ? (~prod + (2*WIDTH)'(1)) : prod;
    quo_fix  = dz_q ? {WIDTH{1'b1}} : (neg_q ? (~shreg_q + WIDTH'(1)) : shreg_q);
    rem_fix  = rem_neg_q ? (~acc_q + WIDTH'(1)) : acc_q;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    shreg_d   = shreg_q;
    opnd_d    = opnd_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    dz_d      = dz_q;
    hi_d      = mthi_i ? wd_i : hi_q;
    lo_d      = mtlo_i ? wd_i : lo_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i && !cancel_i) begin
          is_div_d  = start_div;
          neg_d     = is_signed & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
          rem_neg_d = is_signed & start_div & a_i[WIDTH-1];
          dz_d      = start_div & (b_i == '0);
          acc_d     = '0;
          cnt_d     = '0;
          shreg_d   = start_div ? a_abs : b_abs;
          opnd_d    = start_div ? b_abs : a_abs;
          state_d   = CALC;
        end
      end
      CALC: begin
        if (cancel_i) begin
          state_d = IDLE;
        end else begin
          acc_d   = step_acc;
          shreg_d = step_shreg;
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CNT) begin
            state_d = FIX;
          end
        end
      end
      FIX: begin
        state_d = IDLE;
        if (!cancel_i) begin
          if (is_div_q) begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end else begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end
          done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      shreg_q   <= '0;
      opnd_q    <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      dz_q      <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      shreg_q   <= shreg_d;
      opnd_q    <= opnd_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      dz_q      <= dz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign hi_o   = hi_q;
  assign lo_o   = lo_q;
  assign busy_o = (state_q != IDLE);
  assign done_o = done_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_muldiv_unit : directed self-checking bench for muldiv_unit
// Revision       : 1.0
// ----------------------------------------------------------------------------
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic        cancel_i;
  logic        mthi_i;
  logic        mtlo_i;
  logic [31:0] wd_i;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        busy_o;
  logic        done_o;

  int errors = 0;
  int checks = 0;

  muldiv_unit dut (
    .clk      (clk),
    .rstn     (rstn),
    .start_i  (start_i),
    .op_i     (op_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .cancel_i (cancel_i),
    .mthi_i   (mthi_i),
    .mtlo_i   (mtlo_i),
    .wd_i     (wd_i),
    .hi_o     (hi_o),
    .lo_o     (lo_o),
    .busy_o   (busy_o),
    .done_o   (done_o)
  );

  always #5 clk = ~clk;

  // Observation n is taken at the n-th falling edge after start is driven.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int busy_bad);
    @(negedge clk);
    op_i = op; a_i = a; b_i = b; start_i = 1'b1;
    lat = 0; busy_bad = 0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      start_i = 1'b0;
      if (done_o) begin
        lat = n;
        break;
      end
      if (!busy_o) busy_bad++;
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; start_i = 1'b0; op_i = 2'b00; a_i = '0; b_i = '0;
    cancel_i = 1'b0; mthi_i = 1'b0; mtlo_i = 1'b0; wd_i = '0;
    repeat (3) @(negedge clk);
    checks++; if (hi_o !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h expected %h", hi_o, 32'h0); end
    checks++; if (lo_o !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h expected %h", lo_o, 32'h0); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
    checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done_o); end
    rstn = 1'b1;
  endtask

  task automatic test_multu_latency();
    int lat, bb;
    run_op(2'b01, 32'hFFFF_FFFF, 32'h0000_0002, lat, bb);
    checks++; if (lat !== 34) begin errors++; $display("FAIL multu_latency: got %0d expected 34", lat); end
    checks++; if (bb !== 0) begin errors++; $display("FAIL multu_busy_gap: got %0d low cycles expected 0", bb); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL multu_busy_at_done: got %b expected 0", busy_o); end
    checks++; if (hi_o !== 32'h0000_0001) begin errors++; $display("FAIL multu_hi: got %h expected %h", hi_o, 32'h0000_0001); end
    checks++; if (lo_o !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_lo: got %h expected %h", lo_o, 32'hFFFF_FFFE); end
    @(negedge clk);
    checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL multu_done_width: got %b expected 0", done_o); end
  endtask

  task automatic test_mult_signed();
    int lat, bb;
    run_op(2'b00, 32'hFFFF_FFF9, 32'h0000_0003, lat, bb);
    checks++; if (lat !== 34) begin errors++; $display("FAIL mult_latency: got %0d expected 34", lat); end
    checks++; if (hi_o !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi: got %h expected %h", hi_o, 32'hFFFF_FFFF); end
    checks++; if (lo_o !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mult_lo: got %h expected %h", lo_o, 32'hFFFF_FFEB); end
  endtask

  task automatic test_div_signed();
    int lat, bb;
    run_op(2'b10, 32'hFFFF_FFEF, 32'h0000_0005, lat, bb);
    checks++; if (lo_o !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_lo: got %h expected %h", lo_o, 32'hFFFF_FFFD); end
    checks++; if (hi_o !== 32'hFFFF_FFFE) begin errors++; $display("FAIL div_hi: got %h expected %h", hi_o, 32'hFFFF_FFFE); end
  endtask

  task automatic test_divu_zero();
    int lat, bb;
    run_op(2'b11, 32'h0000_0011, 32'h0000_0000, lat, bb);
    checks++; if (lat !== 34) begin errors++; $display("FAIL divz_latency: got %0d expected 34", lat); end
    checks++; if (lo_o !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divz_lo: got %h expected %h", lo_o, 32'hFFFF_FFFF); end
    checks++; if (hi_o !== 32'h0000_0011) begin errors++; $display("FAIL divz_hi: got %h expected %h", hi_o, 32'h0000_0011); end
  endtask

  task automatic test_overflow_restart();
    int dones = 0;
    int first = 0;
    @(negedge clk);
    op_i = 2'b10; a_i = 32'h8000_0000; b_i = 32'hFFFF_FFFF; start_i = 1'b1;
    for (int n = 1; n <= 80; n++) begin
      @(negedge clk);
      start_i = 1'b0;
      if (n == 10) begin
        op_i = 2'b01; a_i = 32'h2; b_i = 32'h3; start_i = 1'b1;
      end
      if (done_o) begin
        dones++;
        if (first == 0) first = n;
      end
    end
    checks++; if (dones !== 1) begin errors++; $display("FAIL ovf_done_count: got %0d expected 1", dones); end
    checks++; if (first !== 34) begin errors++; $display("FAIL ovf_latency: got %0d expected 34", first); end
    checks++; if (lo_o !== 32'h8000_0000) begin errors++; $display("FAIL ovf_lo: got %h expected %h", lo_o, 32'h8000_0000); end
    checks++; if (hi_o !== 32'h0) begin errors++; $display("FAIL ovf_hi: got %h expected %h", hi_o, 32'h0); end
  endtask

  task automatic test_mthi_cancel();
    int dones = 0;
    @(negedge clk);
    wd_i = 32'hA5A5_A5A5; mthi_i = 1'b1;
    @(negedge clk);
    mthi_i = 1'b0;
    checks++; if (hi_o !== 32'hA5A5_A5A5) begin errors++; $display("FAIL mthi_hi: got %h expected %h", hi_o, 32'hA5A5_A5A5); end
    checks++; if (lo_o !== 32'h8000_0000) begin errors++; $display("FAIL mthi_lo: got %h expected %h", lo_o, 32'h8000_0000); end
    op_i = 2'b00; a_i = 32'd3; b_i = 32'd4; start_i = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      start_i = 1'b0;
    end
    cancel_i = 1'b1;
    @(negedge clk);
    cancel_i = 1'b0;
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL cancel_busy: got %b expected 0", busy_o); end
    for (int n = 0; n < 40; n++) begin
      if (done_o) dones++;
      @(negedge clk);
    end
    checks++; if (dones !== 0) begin errors++; $display("FAIL cancel_done: got %0d pulses expected 0", dones); end
    checks++; if (hi_o !== 32'hA5A5_A5A5) begin errors++; $display("FAIL cancel_hi: got %h expected %h", hi_o, 32'hA5A5_A5A5); end
    checks++; if (lo_o !== 32'h8000_0000) begin errors++; $display("FAIL cancel_lo: got %h expected %h", lo_o, 32'h8000_0000); end
  endtask

  task automatic test_reset_mid();
    int lat, bb;
    @(negedge clk);
    op_i = 2'b11; a_i = 32'd100; b_i = 32'd7; start_i = 1'b1;
    for (int n = 1; n <= 15; n++) begin
      @(negedge clk);
      start_i = 1'b0;
    end
    rstn = 1'b0;
    #1;
    checks++; if (hi_o !== 32'h0) begin errors++; $display("FAIL rstmid_hi: got %h expected %h", hi_o, 32'h0); end
    checks++; if (lo_o !== 32'h0) begin errors++; $display("FAIL rstmid_lo: got %h expected %h", lo_o, 32'h0); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy_o); end
    @(negedge clk);
    rstn = 1'b1;
    run_op(2'b01, 32'd6, 32'd7, lat, bb);
    checks++; if (lat !== 34) begin errors++; $display("FAIL rstmid_latency: got %0d expected 34", lat); end
    checks++; if (lo_o !== 32'd42) begin errors++; $display("FAIL rstmid_lo42: got %h expected %h", lo_o, 32'd42); end
    checks++; if (hi_o !== 32'h0) begin errors++; $display("FAIL rstmid_hi0: got %h expected %h", hi_o, 32'h0); end
  endtask

  initial begin
    test_reset();
    test_multu_latency();
    test_mult_signed();
    test_div_signed();
    test_divu_zero();
    test_overflow_restart();
    test_mthi_cancel();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
